// File: rtl/cr_kme_fifo_pkg.sv
// Shared constants for the KME stall-FIFO feeder: nibble width,
// FSM state encodings and err_sticky bit positions.
package cr_kme_fifo_pkg;

    // Data width of the KME stall FIFO write port.
    localparam int NIB_W = 4;

    // Feeder FSM states.
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SEND = 1'b1;

    // err_sticky bit positions.
    localparam int ERR_OVF  = 0;
    localparam int ERR_UNF  = 1;
    localparam int ERR_ZLEN = 2;

endpackage

// File: rtl/cr_kme_nib_shifter.sv
// Loadable right-shift register holding a request's nibbles plus a
// down-counter of nibbles still to send. Load wins over shift so that a
// new request can replace the final nibble in the same cycle.
module cr_kme_nib_shifter #(
    parameter int N_NIB = 4,
    parameter int NW    = 4,
    parameter int LW    = $clog2(N_NIB + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic [N_NIB*NW-1:0] data_i,
    input  logic [LW-1:0]       len_i,
    input  logic                shift_i,
    output logic [NW-1:0]       nib_o,
    output logic                last_o
);

    logic [N_NIB*NW-1:0] sr_q, sr_d;
    logic [LW-1:0]       rem_q, rem_d;

    // Next-state: load a new request, or consume one nibble per shift.
    always_comb begin
        sr_d  = sr_q;
        rem_d = rem_q;
        if (load_i) begin
            sr_d  = data_i;
            rem_d = len_i;
        end else if (shift_i) begin
            sr_d  = sr_q >> NW;
            rem_d = rem_q - LW'(1);
        end
    end

    // Shift register and remaining-count state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            rem_q <= '0;
        end else begin
            sr_q  <= sr_d;
            rem_q <= rem_d;
        end
    end

    assign nib_o  = sr_q[NW-1:0];
    assign last_o = (rem_q == LW'(1));

endmodule

// File: rtl/cr_kme_fifo_feeder.sv
// Serialises multi-nibble requests LSB-first into the KME stall FIFO,
// honouring its combinational stall, with sticky error capture and a
// free-running push counter.
module cr_kme_fifo_feeder
    import cr_kme_fifo_pkg::*;
#(
    parameter int N_NIB = 4,
    parameter int NW    = NIB_W,
    parameter int CNT_W = 16,
    parameter int LW    = $clog2(N_NIB + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [N_NIB*NW-1:0] req_data,
    input  logic [LW-1:0]       req_len,
    input  logic                fifo_in_stall,
    output logic [NW-1:0]       fifo_in,
    output logic                fifo_in_valid,
    input  logic                fifo_overflow,
    input  logic                fifo_underflow,
    input  logic                err_clr,
    output logic [2:0]          err_sticky,
    output logic [CNT_W-1:0]    push_cnt,
    output logic                busy
);

    logic             state_q, state_d;
    logic [2:0]       err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last;
    logic             push, accept, load, zlen;

    // A push needs SEND and no stall; rst suppresses it so a reset never
    // leaves a partial write in the FIFO.
    assign push      = (state_q == ST_SEND) && !fifo_in_stall && !rst;
    // Ready in the final-push cycle lets back-to-back requests stream.
    assign req_ready = (state_q == ST_IDLE) ||
                       ((state_q == ST_SEND) && last && !fifo_in_stall);
    assign accept    = req_valid && req_ready;
    assign load      = accept && (req_len != '0);
    assign zlen      = accept && (req_len == '0);

    cr_kme_nib_shifter #(
        .N_NIB (N_NIB),
        .NW    (NW),
        .LW    (LW)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .data_i  (req_data),
        .len_i   (req_len),
        .shift_i (push),
        .nib_o   (fifo_in),
        .last_o  (last)
    );

    // FSM, sticky errors (set beats clear) and push counter next-state.
    always_comb begin
        state_d = state_q;
        if (load)
            state_d = ST_SEND;
        else if (push && last)
            state_d = ST_IDLE;

        err_d = err_q;
        if (err_clr)
            err_d = '0;
        err_d[ERR_OVF]  = err_d[ERR_OVF]  | fifo_overflow;
        err_d[ERR_UNF]  = err_d[ERR_UNF]  | fifo_underflow;
        err_d[ERR_ZLEN] = err_d[ERR_ZLEN] | zlen;

        cnt_d = cnt_q + CNT_W'(push);
    end

    // Registered state; rst has priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            err_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fifo_in_valid = push;
    assign err_sticky    = err_q;
    assign push_cnt      = cnt_q;
    assign busy          = (state_q == ST_SEND);

endmodule

// File: tb/tb_cr_kme_fifo_feeder.sv
// Directed, table-driven bench for cr_kme_fifo_feeder. Each row is one
// clock cycle: inputs are driven after the falling edge and outputs are
// checked 1ns later, so rows describe what is visible during that cycle.
module tb_cr_kme_fifo_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_data;
    logic [2:0]  req_len;
    logic        fifo_in_stall;
    logic [3:0]  fifo_in;
    logic        fifo_in_valid;
    logic        fifo_overflow;
    logic        fifo_underflow;
    logic        err_clr;
    logic [2:0]  err_sticky;
    logic [15:0] push_cnt;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cr_kme_fifo_feeder dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_data       (req_data),
        .req_len        (req_len),
        .fifo_in_stall  (fifo_in_stall),
        .fifo_in        (fifo_in),
        .fifo_in_valid  (fifo_in_valid),
        .fifo_overflow  (fifo_overflow),
        .fifo_underflow (fifo_underflow),
        .err_clr        (err_clr),
        .err_sticky     (err_sticky),
        .push_cnt       (push_cnt),
        .busy           (busy)
    );

    typedef struct {
        logic        rst, rv;
        logic [15:0] data;
        logic [2:0]  len;
        logic        stall, ovf, unf, clr;
        logic        e_val;
        logic [3:0]  e_in;
        logic        e_rdy, e_busy;
        logic [2:0]  e_err;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic v, logic [15:0] d, logic [2:0] l,
                                logic s, logic o, logic u, logic c,
                                logic ev, logic [3:0] ei, logic er, logic eb,
                                logic [2:0] ee, logic [15:0] ec);
        vec_t t;
        t.rst = r; t.rv = v; t.data = d; t.len = l;
        t.stall = s; t.ovf = o; t.unf = u; t.clr = c;
        t.e_val = ev; t.e_in = ei; t.e_rdy = er; t.e_busy = eb;
        t.e_err = ee; t.e_cnt = ec;
        return t;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst; req_valid = t.rv; req_data = t.data; req_len = t.len;
        fifo_in_stall = t.stall; fifo_overflow = t.ovf;
        fifo_underflow = t.unf; err_clr = t.clr;
    endtask

    // Stall toggles every cycle during a 4-nibble send: exactly one push
    // per unstalled cycle, nibbles in order, none lost or repeated.
    task automatic stall_toggle_seq();
        logic [3:0] got[$];
        logic [3:0] exp_n[4] = '{4'hC, 4'hD, 4'hE, 4'hF};
        @(negedge clk);
        drive(mk(0,1,16'hFEDC,3'd4,0,0,0,0, 0,0,0,0,0,0));
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            fifo_in_stall = cyc[0];
            #1;
            if (busy)
                chk("toggle_valid", cyc, {31'd0, fifo_in_valid}, {31'd0, !fifo_in_stall});
            if (fifo_in_valid)
                got.push_back(fifo_in);
        end
        chk("toggle_count", 0, got.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("toggle_nib", i, (i < got.size()) ? {28'd0, got[i]} : 32'hFFFF_FFFF,
                {28'd0, exp_n[i]});
        chk("toggle_cnt", 0, {16'd0, push_cnt}, 32'd6);
        chk("toggle_idle", 0, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        //           rst rv data     len st ov un cl | val in   rdy busy err   cnt
        // reset state
        vq.push_back(mk(0,0,16'h0000,3'd0,0,0,0,0, 0,4'h0,1,0,3'b000,16'd0));
        // single 4-nibble request, no stall
        vq.push_back(mk(0,1,16'h4321,3'd4,0,0,0,0, 0,4'h0,1,0,3'b000,16'd0));
        vq.push_back(mk(0,0,16'h0000,3'd0,0,0,0,0, 1,4'h1,0,1,3'b000,16'd0));
        vq.push_back(mk(0,0,16'h0000,3'd0,0,0,0,0, 1,4'h2,0,1,3'b000,16'd1));
        vq.push_back(mk(0,0,16'h0000,3'd0,0,0,0,0, 1,4'h3,0,1,3'b000,16'd2));
        vq.push_back(mk(0,0,16'h0000,3'd0,0,0,0,0, 1,4'h4,1,1,3'b000,16'd3));
        vq.push_back(mk(0,0,16'h0000,3'd0,0,0,0,0, 0,4'h0,1,0,3'b000,16'd4));
        // stall for two cycles after the first push
        vq.push_back(mk(0,1,16'h0CBA,3'd3,0,0,0,0, 0,4'h0,1,0,3'b000,16'd4));
        vq.push_back(mk(0,0,16'h0000,3'd0,0,0,0,0, 1,4'hA,0,1,3'b000,16'd4));
        vq.push_back(mk(0,0,16'h0000,3'd0,1,0,0,0, 0,4'h0,0,1,3'b000,16'd5));
        vq.push_back(mk(0,0,16'h0000,3'd0,1,0,0,0, 0,4'h0,0,1,3'b000,16'd5));
        vq.push_back(mk(0,0,16'h0000,3'd0,0,0,0,0, 1,4'hB,0,1,3'b000,16'd5));
        vq.push_back(mk(0,0,16'h0000,3'd0,0,0,0,0, 1,4'hC,1,1,3'b000,16'd6));
        vq.push_back(mk(0,0,16'h0000,3'd0,0,0,0,0, 0,4'h0,1,0,3'b000,16'd7));
        // back-to-back, plus a stall on the final nibble (ready must drop)
        vq.push_back(mk(0,1,16'h0021,3'd2,0,0,0,0, 0,4'h0,1,0,3'b000,16'd7));
        vq.push_back(mk(0,1,16'h0043,3'd2,0,0,0,0, 1,4'h1,0,1,3'b000,16'd7));
        vq.push_back(mk(0,1,16'h0043,3'd2,0,0,0,0, 1,4'h2,1,1,3'b000,16'd8));
        vq.push_back(mk(0,0,16'h0000,3'd0,0,0,0,0, 1,4'h3,0,1,3'b000,16'd9));
        vq.push_back(mk(0,0,16'h0000,3'd0,1,0,0,0, 0,4'h0,0,1,3'b000,16'd10));
        vq.push_back(mk(0,0,16'h0000,3'd0,0,0,0,0, 1,4'h4,1,1,3'b000,16'd10));
        vq.push_back(mk(0,0,16'h0000,3'd0,0,0,0,0, 0,4'h0,1,0,3'b000,16'd11));
        // zero-length request, then clear
        vq.push_back(mk(0,1,16'hFFFF,3'd0,0,0,0,0, 0,4'h0,1,0,3'b000,16'd11));
        vq.push_back(mk(0,0,16'h0000,3'd0,0,0,0,1, 0,4'h0,1,0,3'b100,16'd11));
        vq.push_back(mk(0,0,16'h0000,3'd0,0,0,0,0, 0,4'h0,1,0,3'b000,16'd11));
        // overflow+underflow with simultaneous clear: set wins
        vq.push_back(mk(0,0,16'h0000,3'd0,0,1,1,1, 0,4'h0,1,0,3'b000,16'd11));
        vq.push_back(mk(0,0,16'h0000,3'd0,0,0,0,0, 0,4'h0,1,0,3'b011,16'd11));
        vq.push_back(mk(0,0,16'h0000,3'd0,0,0,0,1, 0,4'h0,1,0,3'b011,16'd11));
        vq.push_back(mk(0,0,16'h0000,3'd0,0,0,0,0, 0,4'h0,1,0,3'b000,16'd11));
        // reset after two of four pushes
        vq.push_back(mk(0,1,16'h8765,3'd4,0,0,0,0, 0,4'h0,1,0,3'b000,16'd11));
        vq.push_back(mk(0,0,16'h0000,3'd0,0,0,0,0, 1,4'h5,0,1,3'b000,16'd11));
        vq.push_back(mk(0,0,16'h0000,3'd0,0,0,0,0, 1,4'h6,0,1,3'b000,16'd12));
        vq.push_back(mk(1,0,16'h0000,3'd0,0,0,0,0, 0,4'h0,0,1,3'b000,16'd13));
        vq.push_back(mk(0,0,16'h0000,3'd0,0,0,0,0, 0,4'h0,1,0,3'b000,16'd0));
        vq.push_back(mk(0,1,16'h00DC,3'd2,0,0,0,0, 0,4'h0,1,0,3'b000,16'd0));
        vq.push_back(mk(0,0,16'h0000,3'd0,0,0,0,0, 1,4'hC,0,1,3'b000,16'd0));
        vq.push_back(mk(0,0,16'h0000,3'd0,0,0,0,0, 1,4'hD,1,1,3'b000,16'd1));
        // stall in IDLE must not push nor drop ready
        vq.push_back(mk(0,0,16'h0000,3'd0,1,0,0,0, 0,4'h0,1,0,3'b000,16'd2));

        drive(mk(1,0,16'h0,3'd0,0,0,0,0, 0,0,0,0,0,0));
        repeat (2) @(posedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i]);
            #1;
            chk("fifo_in_valid", i, {31'd0, fifo_in_valid}, {31'd0, vq[i].e_val});
            chk("req_ready",     i, {31'd0, req_ready},     {31'd0, vq[i].e_rdy});
            chk("busy",          i, {31'd0, busy},          {31'd0, vq[i].e_busy});
            chk("err_sticky",    i, {29'd0, err_sticky},    {29'd0, vq[i].e_err});
            chk("push_cnt",      i, {16'd0, push_cnt},      {16'd0, vq[i].e_cnt});
            if (vq[i].e_val)
                chk("fifo_in",   i, {28'd0, fifo_in},       {28'd0, vq[i].e_in});
        end

        stall_toggle_seq();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
